cordic_scheduler: RTL and testbench

Two-requester scheduler that shares one fully pipelined CORDIC rotation datapath. The CORDIC `mode` input is global to every pipeline stage, so mode changes are only safe when the pipeline is empty. This block therefore:
- arbitrates round-robin among requesters that want the currently locked mode;
- drains the pipeline before switching mode;
- tracks in-flight ownership with a tag shift register;
- steers each result into a per-requester result FIFO, using credit-based issue so no result is ever dropped.

---
 rtl/cordic_scheduler.sv | 161 ++++++++++++++++
 tb/tb_cordic_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_scheduler.sv
// Two-requester front end for a shared, fully pipelined CORDIC. The mode is locked per
// batch, with a drain before each switch, and results return through credit-reserved FIFOs.
module cordic_scheduler #(
  parameter int PIPE_LATENCY = 29,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  in_valid,
  output logic [1:0]  in_ready,
  input  logic [63:0] in_x,
  input  logic [63:0] in_y,
  input  logic [63:0] in_angle,
  input  logic [3:0]  in_mode,
  output logic [1:0]  out_valid,
  input  logic [1:0]  out_ready,
  output logic [63:0] out_x,
  output logic [63:0] out_y,
  output logic [63:0] out_angle,
  output logic [31:0] cordic_x,
  output logic [31:0] cordic_y,
  output logic [31:0] cordic_angle,
  output logic [1:0]  cordic_mode,
  input  logic [31:0] cordic_rx,
  input  logic [31:0] cordic_ry,
  input  logic [31:0] cordic_rangle,
  output logic        busy
);
  localparam int CW = $clog2(FIFO_DEPTH + PIPE_LATENCY) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                         r_state, w_state_nxt;
  logic                           r_rr, w_rr_nxt;
  logic [1:0]                     r_cur_mode, w_cur_mode_nxt;
  logic [1:0]                     r_next_mode, w_next_mode_nxt;
  logic [1:0][CW-1:0]             r_fcnt, r_infl;
  logic [1:0][FIFO_DEPTH-1:0][95:0] r_mem;
  logic [1:0][AW-1:0]             r_wp, r_rp;
  logic [PIPE_LATENCY-1:0]        r_vld_pipe, r_own_pipe;
  logic [1:0]                     w_elig, w_grant, w_wb, w_pop;
  logic                           w_prio, w_gsel, w_issue;
  logic [1:0]                     w_prio_mode;
  logic [CW:0]                    w_infl_total;

  // Credit covers both queued results and ops still in the pipe, so a writeback always has room.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      w_elig[r] = in_valid[r] && (in_mode[2*r +: 2] == r_cur_mode)
                  && ((r_fcnt[r] + r_infl[r]) < DEPTH_C);
      w_wb[r]   = r_vld_pipe[PIPE_LATENCY-1] && (r_own_pipe[PIPE_LATENCY-1] == 1'(r));
    end
  end

  assign w_prio       = in_valid[r_rr] ? r_rr : ~r_rr;
  assign w_prio_mode  = w_prio ? in_mode[3:2] : in_mode[1:0];
  assign w_infl_total = {1'b0, r_infl[0]} + {1'b0, r_infl[1]};

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_nxt        = r_rr;
    w_cur_mode_nxt  = r_cur_mode;
    w_next_mode_nxt = r_next_mode;
    w_grant         = 2'b00;
    case (r_state)
      IDLE: if (|in_valid) begin
        w_cur_mode_nxt = w_prio_mode;
        w_state_nxt    = RUN;
      end
      RUN: begin
        if (in_valid[w_prio] && (w_prio_mode != r_cur_mode)) begin
          w_next_mode_nxt = w_prio_mode;
          w_state_nxt     = DRAIN;
        end else if (w_elig[r_rr]) begin
          w_grant[r_rr] = 1'b1;
          w_rr_nxt      = ~r_rr;
        end else if (w_elig[~r_rr]) begin
          w_grant[~r_rr] = 1'b1;
          w_rr_nxt       = r_rr;
        end else if ((in_valid == 2'b00) && (w_infl_total == '0)) begin
          w_state_nxt = IDLE;
        end
      end
      DRAIN: if (w_infl_total == '0) begin
        w_cur_mode_nxt = r_next_mode;
        w_state_nxt    = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready    = w_grant;
  assign w_issue     = |w_grant;
  assign w_gsel      = w_grant[1];
  assign cordic_mode = r_cur_mode;
  assign busy        = (r_state != IDLE) || (w_infl_total != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rr         <= 1'b0;
      r_cur_mode   <= 2'b10;
      r_next_mode  <= 2'b10;
      cordic_x     <= '0;
      cordic_y     <= '0;
      cordic_angle <= '0;
      r_vld_pipe   <= '0;
      r_own_pipe   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr         <= w_rr_nxt;
      r_cur_mode   <= w_cur_mode_nxt;
      r_next_mode  <= w_next_mode_nxt;
      cordic_x     <= w_issue ? (w_gsel ? in_x[63:32]     : in_x[31:0])     : '0;
      cordic_y     <= w_issue ? (w_gsel ? in_y[63:32]     : in_y[31:0])     : '0;
      cordic_angle <= w_issue ? (w_gsel ? in_angle[63:32] : in_angle[31:0]) : '0;
      r_vld_pipe   <= {r_vld_pipe[PIPE_LATENCY-2:0], w_issue};
      r_own_pipe   <= {r_own_pipe[PIPE_LATENCY-2:0], w_gsel};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fcnt <= '0;
      r_infl <= '0;
      r_mem  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        r_infl[r] <= r_infl[r] + CW'(w_grant[r]) - CW'(w_wb[r]);
        r_fcnt[r] <= r_fcnt[r] + CW'(w_wb[r]) - CW'(w_pop[r]);
        if (w_wb[r]) begin
          r_mem[r][r_wp[r]] <= {cordic_rx, cordic_ry, cordic_rangle};
          r_wp[r]           <= r_wp[r] + AW'(1);
        end
        if (w_pop[r]) r_rp[r] <= r_rp[r] + AW'(1);
      end
    end
  end

  // Head data is zeroed while empty so stale entries never leak onto the outputs.
  always_comb begin
    out_x     = '0;
    out_y     = '0;
    out_angle = '0;
    for (int r = 0; r < 2; r++) begin
      out_valid[r] = (r_fcnt[r] != '0);
      w_pop[r]     = out_valid[r] && out_ready[r];
      if (out_valid[r])
        {out_x[32*r +: 32], out_y[32*r +: 32], out_angle[32*r +: 32]} = r_mem[r][r_rp[r]];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_chk
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      w_wb[g] |-> (r_fcnt[g] < DEPTH_C));
  end
endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler; a delay-line stand-in for the CORDIC returns
// x+1, y+2, angle+3 so every result is predictable from the issued operands.
module tb_cordic_scheduler;
  localparam int L = 29;

  logic        clock, reset;
  logic [1:0]  in_valid, in_ready, out_valid, out_ready, cordic_mode;
  logic [63:0] in_x, in_y, in_angle, out_x, out_y, out_angle;
  logic [3:0]  in_mode;
  logic [31:0] cordic_x, cordic_y, cordic_angle, cordic_rx, cordic_ry, cordic_rangle;
  logic        busy;
  int checks, errors;

  cordic_scheduler #(.PIPE_LATENCY(L), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_angle(in_angle), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_angle(out_angle), .cordic_x(cordic_x), .cordic_y(cordic_y),
    .cordic_angle(cordic_angle), .cordic_mode(cordic_mode), .cordic_rx(cordic_rx),
    .cordic_ry(cordic_ry), .cordic_rangle(cordic_rangle), .busy(busy));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // L-1 register stages so the result is on cordic_r* just before edge E0+L.
  logic [31:0] dx [0:L-2];
  logic [31:0] dy [0:L-2];
  logic [31:0] da [0:L-2];
  always @(posedge clock) begin
    dx[0] <= cordic_x; dy[0] <= cordic_y; da[0] <= cordic_angle;
    for (int i = 1; i < L-1; i++) begin
      dx[i] <= dx[i-1]; dy[i] <= dy[i-1]; da[i] <= da[i-1];
    end
  end
  assign cordic_rx     = dx[L-2] + 32'd1;
  assign cordic_ry     = dy[L-2] + 32'd2;
  assign cordic_rangle = da[L-2] + 32'd3;

  function automatic logic [31:0] op_x(input int r, input int k);
    return 32'((r + 1) << 28) + 32'(k);
  endfunction
  function automatic logic [31:0] op_y(input int r, input int k);
    return 32'(k * 256 + r);
  endfunction
  function automatic logic [31:0] op_a(input int r, input int k);
    return 32'h0100_0000 + 32'(k * 3 + r);
  endfunction
  function automatic logic [95:0] res(input int r, input int k);
    return {op_x(r, k) + 32'd1, op_y(r, k) + 32'd2, op_a(r, k) + 32'd3};
  endfunction
  function automatic logic [95:0] head(input int r);
    return {out_x[32*r +: 32], out_y[32*r +: 32], out_angle[32*r +: 32]};
  endfunction

  task automatic set_op(input int r, input int k);
    in_x[32*r +: 32]     = op_x(r, k);
    in_y[32*r +: 32]     = op_y(r, k);
    in_angle[32*r +: 32] = op_a(r, k);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; in_valid = 2'b00; out_ready = 2'b11; in_mode = 4'b1010;
    in_x = '0; in_y = '0; in_angle = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 2'b11; out_ready = 2'b11; in_mode = 4'b1010;
    in_x = '0; in_y = '0; in_angle = '0;
    tick(); tick();
    checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL rst_in_ready got %b exp 00", in_ready); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL rst_out_valid got %b exp 00", out_valid); end
    checks++; if ({out_x, out_y, out_angle} !== '0) begin errors++; $display("FAIL rst_out_data got %h exp 0", {out_x, out_y, out_angle}); end
    checks++; if ({cordic_x, cordic_y, cordic_angle} !== '0) begin errors++; $display("FAIL rst_cordic_ops got %h exp 0", {cordic_x, cordic_y, cordic_angle}); end
    checks++; if (cordic_mode !== 2'b10) begin errors++; $display("FAIL rst_mode got %b exp 10", cordic_mode); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    in_valid = 2'b00;
    reset = 1'b0;
  endtask

  task automatic test_single_op;
    apply_reset();
    in_x[31:0] = 32'h4000_0000; in_y[31:0] = 32'h0; in_angle[31:0] = 32'h1000_0000;
    in_valid = 2'b01;
    #1;
    checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL single_idle_ready got %b exp 00", in_ready); end
    tick();
    checks++; if (in_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", in_ready); end
    tick();  // E0
    in_valid = 2'b00;
    #1;
    checks++; if ({cordic_x, cordic_y, cordic_angle} !== {32'h4000_0000, 32'h0, 32'h1000_0000}) begin
      errors++; $display("FAIL single_ops got %h", {cordic_x, cordic_y, cordic_angle}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    for (int i = 1; i <= L-1; i++) tick();
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL single_early got %b exp 00", out_valid); end
    tick();  // E0+29
    checks++; if (out_valid !== 2'b01) begin errors++; $display("FAIL single_latency got %b exp 01", out_valid); end
    checks++; if (head(0) !== {32'h4000_0001, 32'h2, 32'h1000_0003}) begin
      errors++; $display("FAIL single_data got %h", head(0)); end
    tick();
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL single_pop got %b exp 00", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_round_robin;
    int k[2];
    int got[2];
    logic [1:0] acc;
    logic e;
    apply_reset();
    k = '{0, 0}; got = '{0, 0}; e = 1'b0;
    set_op(0, 0); set_op(1, 0);
    in_valid = 2'b11;
    tick();
    for (int n = 0; n < 8; n++) begin
      checks++; if (in_ready !== (e ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant%0d got %b exp %b", n, in_ready, e ? 2'b10 : 2'b01); end
      acc = in_valid & in_ready;
      tick();
      for (int r = 0; r < 2; r++) if (acc[r]) begin
        k[r]++;
        if (k[r] == 4) in_valid[r] = 1'b0; else set_op(r, k[r]);
      end
      e = ~e;
    end
    in_valid = 2'b00;
    for (int c = 0; c < 45; c++) begin
      for (int r = 0; r < 2; r++) if (out_valid[r]) begin
        checks++; if (head(r) !== res(r, got[r])) begin
          errors++; $display("FAIL rr_data r%0d n%0d got %h exp %h", r, got[r], head(r), res(r, got[r])); end
        got[r]++;
      end
      tick();
    end
    checks++; if (got[0] != 4 || got[1] != 4) begin
      errors++; $display("FAIL rr_count got %0d/%0d exp 4/4", got[0], got[1]); end
  endtask

  task automatic test_mode_switch;
    apply_reset();
    in_mode = 4'b0010;
    set_op(0, 0); set_op(1, 0);
    in_valid = 2'b11;
    tick();
    checks++; if (in_ready !== 2'b01) begin errors++; $display("FAIL ms_first got %b exp 01", in_ready); end
    tick();  // E0
    in_valid = 2'b10;
    for (int i = 0; i <= L; i++) begin
      #1;
      checks++; if (in_ready !== 2'b00 || cordic_mode !== 2'b10) begin
        errors++; $display("FAIL ms_drain c%0d ready %b mode %b exp 00/10", i, in_ready, cordic_mode); end
      if (i < L) tick();
    end
    tick();  // E0+30
    checks++; if (cordic_mode !== 2'b00) begin errors++; $display("FAIL ms_mode got %b exp 00", cordic_mode); end
    checks++; if (in_ready !== 2'b10) begin errors++; $display("FAIL ms_grant1 got %b exp 10", in_ready); end
    tick();
    in_valid = 2'b00;
    checks++; if (cordic_x !== op_x(1, 0)) begin errors++; $display("FAIL ms_op got %h exp %h", cordic_x, op_x(1, 0)); end
    for (int c = 0; c < 40 && !out_valid[1]; c++) tick();
    checks++; if (out_valid[1] !== 1'b1 || head(1) !== res(1, 0)) begin
      errors++; $display("FAIL ms_result valid %b got %h exp %h", out_valid[1], head(1), res(1, 0)); end
  endtask

  task automatic test_credit_stall;
    int g;
    logic [1:0] acc;
    apply_reset();
    out_ready = 2'b10;
    set_op(0, 0);
    in_valid = 2'b01;
    g = 0;
    for (int c = 0; c < 45; c++) begin
      acc = in_valid & in_ready;
      tick();
      if (acc[0]) begin g++; set_op(0, g); end
    end
    checks++; if (g != 4) begin errors++; $display("FAIL cs_issues got %0d exp 4", g); end
    checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL cs_stall got %b exp 0", in_ready[0]); end
    checks++; if (out_valid[0] !== 1'b1 || head(0) !== res(0, 0)) begin
      errors++; $display("FAIL cs_head0 got %h exp %h", head(0), res(0, 0)); end
    out_ready = 2'b11;
    tick();
    out_ready = 2'b10;
    g = 0;
    for (int c = 0; c < 45; c++) begin
      acc = in_valid & in_ready;
      tick();
      if (acc[0]) begin g++; set_op(0, 4 + g); end
    end
    checks++; if (g != 1) begin errors++; $display("FAIL cs_one_more got %0d exp 1", g); end
    checks++; if (head(0) !== res(0, 1)) begin errors++; $display("FAIL cs_head1 got %h exp %h", head(0), res(0, 1)); end
    in_valid = 2'b00;
  endtask

  task automatic test_simultaneous;
    int g, k, got;
    logic [1:0] acc;
    apply_reset();
    out_ready = 2'b00;
    set_op(0, 0);
    in_valid = 2'b01;
    tick();
    tick();  // E0: A
    set_op(0, 1);
    tick();  // E0+1: B
    in_valid = 2'b00;
    for (int i = 0; i < L-1; i++) tick();  // E0+29
    checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL sim_wb_a got %b exp 1", out_valid[0]); end
    out_ready = 2'b01;
    set_op(0, 2);
    in_valid = 2'b01;
    #1;
    checks++; if (in_ready !== 2'b01) begin errors++; $display("FAIL sim_issue got %b exp 01", in_ready); end
    tick();  // E0+30: writeback B, pop A, issue C
    out_ready = 2'b00;
    checks++; if (out_valid[0] !== 1'b1 || head(0) !== res(0, 1)) begin
      errors++; $display("FAIL sim_head got %h exp %h", head(0), res(0, 1)); end
    k = 3; g = 0;
    set_op(0, k);
    for (int c = 0; c < 6; c++) begin
      acc = in_valid & in_ready;
      tick();
      if (acc[0]) begin g++; k++; set_op(0, k); end
    end
    checks++; if (g != 2) begin errors++; $display("FAIL sim_credit got %0d exp 2", g); end
    in_valid = 2'b00;
    out_ready = 2'b01;
    got = 1;
    for (int c = 0; c < 45; c++) begin
      if (out_valid[0]) begin
        checks++; if (head(0) !== res(0, got)) begin
          errors++; $display("FAIL sim_order n%0d got %h exp %h", got, head(0), res(0, got)); end
        got++;
      end
      tick();
    end
    checks++; if (got != 5) begin errors++; $display("FAIL sim_fifo_count got %0d exp 5", got); end
  endtask

  task automatic test_reset_midflight;
    int n;
    int k[2];
    logic [1:0] acc;
    logic bad;
    apply_reset();
    n = 0; k = '{0, 0};
    set_op(0, 0); set_op(1, 0);
    in_valid = 2'b11;
    tick();
    for (int c = 1; c <= 9; c++) begin
      acc = in_valid & in_ready;
      tick();
      for (int r = 0; r < 2; r++) if (acc[r]) begin n++; k[r]++; set_op(r, k[r]); end
      if (n >= 5) in_valid = 2'b00;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL mr_issued got %0d exp 5", n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mr_busy_pre got %b exp 1", busy); end
    reset = 1'b1;
    in_valid = 2'b11;
    #1;
    checks++; if (in_ready !== 2'b00 || out_valid !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL mr_ctrl ready %b valid %b busy %b exp 00/00/0", in_ready, out_valid, busy); end
    checks++; if ({cordic_x, cordic_y, cordic_angle, out_x, out_y, out_angle} !== '0 || cordic_mode !== 2'b10) begin
      errors++; $display("FAIL mr_data cordic %h mode %b", {cordic_x, cordic_y, cordic_angle}, cordic_mode); end
    tick();
    in_valid = 2'b00;
    reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (out_valid !== 2'b00) bad = 1'b1;
      tick();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mr_no_results got out_valid after reset"); end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_mode_switch();
    test_credit_stall();
    test_simultaneous();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
